sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 s_in  input  1  serial data bit.
REQ-005 s_valid  input  1  s_in qualifier; one bit accepted per cycle with s_valid=1.
REQ-006 s_first  input  1  start-of-word marker, meaningful only with s_valid=1.
REQ-007 msb_first  input  1  1 = first bit received lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].
REQ-008 dout  output  WIDTH  completed parallel word.
REQ-009 dout_valid  output  1  dout holds an unconsumed word.
REQ-010 dout_ready  input  1  consumer accepts dout on any edge where dout_valid=1 and dout_ready=1.
REQ-011 bit_cnt  output  $clog2(WIDTH+1)  bits collected in the current partial word.
REQ-012 overrun  output  1  sticky: a completed word was dropped.
REQ-013 sync_err  output  1  sticky: s_first arrived with a partial word pending.
REQ-014 err_clr  input  1  clears overrun and sync_err.

Function
REQ-015 Collector states: IDLE (bit_cnt=0) and SHIFT (0<bit_cnt<WIDTH); output states: EMPTY (dout_valid=0) and FULL (dout_valid=1).
REQ-016 Cycles with s_valid=0 leave the shift register and bit_cnt unchanged.
REQ-017 msb_first is latched when a word's first bit is accepted; changes mid-word are ignored until the next word starts.
REQ-018 msb_first latched 1: each accepted bit shifts in at the LSB (register shifts left); latched 0: each accepted bit shifts in at the MSB (register shifts right).
REQ-019 In IDLE, an accepted bit starts a word regardless of s_first: bit_cnt becomes 1 and the state moves to SHIFT.
REQ-020 In SHIFT, an accepted bit with s_first=1 discards the partial word, sets sync_err, and starts a new word with this bit (bit_cnt=1).
REQ-021 In SHIFT, an accepted bit with s_first=0 increments bit_cnt.
REQ-022 Acceptance of bit WIDTH completes the word: bit_cnt returns to 0 (IDLE) on that edge.
REQ-023 Completion in EMPTY: dout takes the word and dout_valid=1 on the same edge, one cycle after the last bit is presented (latency 1).
REQ-024 Completion in FULL with dout_ready=1 on that edge: dout takes the new word and dout_valid stays 1.
REQ-025 Completion in FULL with dout_ready=0: the new word is dropped, dout is unchanged, and overrun is set.
REQ-026 No completion with dout_valid=1 and dout_ready=1: dout_valid becomes 0 on the next edge and dout holds its last value.
REQ-027 dout changes only on a completion edge; it is stable while dout_valid=1 and dout_ready=0.
REQ-028 err_clr=1 clears both sticky flags; if a set event occurs on the same edge, the set wins.
REQ-029 The collector keeps accepting bits while in FULL; backpressure never stalls s_valid.

Reset
REQ-030 rst_n=0 on an edge: dout=0, dout_valid=0, bit_cnt=0, overrun=0, sync_err=0, shift register=0, latched msb_first=1.
REQ-031 Reset has priority over all inputs and discards any partial or held word, including a reset asserted mid-word.

Verification
REQ-032 WIDTH=8, msb_first=1, bits 1,1,0,0,0,0,0,1 on consecutive cycles, s_first on the first bit, dout_ready=0 -> dout=8'hC1, dout_valid=1 from the cycle after bit 8, bit_cnt=0.
REQ-033 Same bits with msb_first=0 -> dout=8'h83; toggling msb_first after bit 3 still yields 8'h83.
REQ-034 dout_ready=0, two full words 8'hC1 then 8'h3C -> overrun=1, dout stays 8'hC1; err_clr pulse -> overrun=0.
REQ-035 dout_ready=1 held on the edge where word 2 (8'h3C) completes -> dout=8'h3C, dout_valid stays 1, overrun=0.
REQ-036 Three bits accepted, then s_first with a new 8-bit word 8'hA5 -> sync_err=1, dout=8'hA5, no word emitted from the 3-bit fragment.
REQ-037 rst_n=0 for one cycle after bit 5 of a word -> all outputs 0; the next 8 bits form a complete word correctly.

Source files
------------

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input, parallel output handshake and status bundle
interface sipo_deser_if #(parameter int WIDTH = 8);
    logic                         s_in;
    logic                         s_valid;
    logic                         s_first;
    logic                         msb_first;
    logic [WIDTH-1:0]             dout;
    logic                         dout_valid;
    logic                         dout_ready;
    logic [$clog2(WIDTH+1)-1:0]   bit_cnt;
    logic                         overrun;
    logic                         sync_err;
    logic                         err_clr;
    modport master (
        output s_in, s_valid, s_first, msb_first, dout_ready, err_clr,
        input  dout, dout_valid, bit_cnt, overrun, sync_err
    );
    modport slave (
        input  s_in, s_valid, s_first, msb_first, dout_ready, err_clr,
        output dout, dout_valid, bit_cnt, overrun, sync_err
    );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with word framing, backpressure and sticky errors
module sipo_deser #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    sipo_deser_if.slave  bus
);
    localparam int CW = $clog2(WIDTH+1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n, dout_r, dout_n;
    logic [CW-1:0]    cnt, cnt_n, cnt_inc;
    logic             msb_l, msb_n, valid_r, valid_n, ovr, ovr_n, serr, serr_n;
    logic             start, done, load;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            msb_l   <= 1'b1;
            dout_r  <= '0;
            valid_r <= 1'b0;
            ovr     <= 1'b0;
            serr    <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            msb_l   <= msb_n;
            dout_r  <= dout_n;
            valid_r <= valid_n;
            ovr     <= ovr_n;
            serr    <= serr_n;
        end
    end
    // A word starts on any accepted bit in IDLE, or on s_first mid-word (resync)
    always_comb begin
        start   = bus.s_valid && (state == IDLE || bus.s_first);
        msb_n   = start ? bus.msb_first : msb_l;
        cnt_inc = start ? CW'(1) : cnt + CW'(1);
        done    = bus.s_valid && cnt_inc == CW'(WIDTH);
        sr_n    = !bus.s_valid ? sr :
                  msb_n ? {sr[WIDTH-2:0], bus.s_in} : {bus.s_in, sr[WIDTH-1:1]};
        cnt_n   = !bus.s_valid ? cnt : done ? '0 : cnt_inc;
        state_n = cnt_n == '0 ? IDLE : SHIFT;
        load    = done && (!valid_r || bus.dout_ready);
        dout_n  = load ? sr_n : dout_r;
        valid_n = load ? 1'b1 : (valid_r && bus.dout_ready) ? 1'b0 : valid_r;
        ovr_n   = (done && valid_r && !bus.dout_ready) || (ovr && !bus.err_clr);
        serr_n  = (bus.s_valid && state == SHIFT && bus.s_first) || (serr && !bus.err_clr);
    end
    assign bus.dout       = dout_r;
    assign bus.dout_valid = valid_r;
    assign bus.bit_cnt    = cnt;
    assign bus.overrun    = ovr;
    assign bus.sync_err   = serr;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed scenario tests for sipo_deser at WIDTH=8
module tb_sipo_deser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    sipo_deser_if #(.WIDTH(8)) bus();
    sipo_deser #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic first);
        bus.s_in = b;
        bus.s_valid = 1'b1;
        bus.s_first = first;
        step();
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic msb);
        bus.msb_first = msb;
        for (int i = 0; i < 8; i++) send_bit(msb ? d[7-i] : d[i], i == 0);
    endtask

    task automatic consume();
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_valid got %b want 0", bus.dout_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if ({bus.dout, bus.dout_valid, bus.bit_cnt, bus.overrun, bus.sync_err} !== '0) begin
            errors++;
            $display("FAIL reset got dout=%h v=%b cnt=%0d ovr=%b serr=%b want all 0",
                     bus.dout, bus.dout_valid, bus.bit_cnt, bus.overrun, bus.sync_err);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] bits = 8'b1100_0001;
        bus.msb_first = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(bits[7-i], i == 0);
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.bit_cnt !== 4'd7) begin
            errors++;
            $display("FAIL msb_partial got v=%b cnt=%0d want v=0 cnt=7", bus.dout_valid, bus.bit_cnt);
        end
        send_bit(bits[0], 1'b0);
        checks++;
        if (bus.dout !== 8'hC1 || bus.dout_valid !== 1'b1 || bus.bit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL msb_word got dout=%h v=%b cnt=%0d want C1 1 0", bus.dout, bus.dout_valid, bus.bit_cnt);
        end
        consume();
        checks++;
        if (bus.dout !== 8'hC1) begin
            errors++;
            $display("FAIL msb_hold got %h want C1", bus.dout);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] bits = 8'b1100_0001;
        bus.msb_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) bus.msb_first = 1'b1;
            send_bit(bits[7-i], i == 0);
        end
        checks++;
        if (bus.dout !== 8'h83 || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL lsb_word got dout=%h v=%b want 83 1", bus.dout, bus.dout_valid);
        end
        consume();
    endtask

    task automatic test_overrun();
        send_word(8'hC1, 1'b1);
        send_word(8'h3C, 1'b1);
        checks++;
        if (bus.overrun !== 1'b1 || bus.dout !== 8'hC1 || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun got ovr=%b dout=%h v=%b want 1 C1 1", bus.overrun, bus.dout, bus.dout_valid);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0 || bus.dout !== 8'hC1) begin
            errors++;
            $display("FAIL overrun_clr got ovr=%b dout=%h want 0 C1", bus.overrun, bus.dout);
        end
        consume();
    endtask

    task automatic test_replace();
        logic [7:0] w = 8'h3C;
        send_word(8'hC1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) bus.dout_ready = 1'b1;
            send_bit(w[7-i], i == 0);
        end
        bus.dout_ready = 1'b0;
        checks++;
        if (bus.dout !== 8'h3C || bus.dout_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL replace got dout=%h v=%b ovr=%b want 3C 1 0", bus.dout, bus.dout_valid, bus.overrun);
        end
        consume();
    endtask

    task automatic test_sync_err();
        logic [7:0] w = 8'hA5;
        bus.msb_first = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(w[7-i], i == 0);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.dout_valid !== 1'b0 || bus.bit_cnt !== 4'd7) begin
            errors++;
            $display("FAIL sync_partial got serr=%b v=%b cnt=%0d want 1 0 7", bus.sync_err, bus.dout_valid, bus.bit_cnt);
        end
        send_bit(w[0], 1'b0);
        checks++;
        if (bus.dout !== 8'hA5 || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL sync_word got dout=%h v=%b want A5 1", bus.dout, bus.dout_valid);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sync_clr got %b want 0", bus.sync_err);
        end
        consume();
    endtask

    task automatic test_idle_gap();
        logic [7:0] w = 8'h5A;
        bus.msb_first = 1'b0;
        send_bit(w[0], 1'b1);
        send_bit(w[1], 1'b0);
        step();
        step();
        step();
        checks++;
        if (bus.bit_cnt !== 4'd2 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_hold got cnt=%0d v=%b want 2 0", bus.bit_cnt, bus.dout_valid);
        end
        for (int i = 2; i < 8; i++) send_bit(w[i], 1'b0);
        checks++;
        if (bus.dout !== 8'h5A || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_word got dout=%h v=%b want 5A 1", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w = 8'hC1;
        bus.msb_first = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(w[7-i], i == 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({bus.dout, bus.dout_valid, bus.bit_cnt, bus.overrun, bus.sync_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid got dout=%h v=%b cnt=%0d ovr=%b serr=%b want all 0",
                     bus.dout, bus.dout_valid, bus.bit_cnt, bus.overrun, bus.sync_err);
        end
        send_word(8'h3C, 1'b1);
        checks++;
        if (bus.dout !== 8'h3C || bus.dout_valid !== 1'b1 || bus.sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_next got dout=%h v=%b serr=%b want 3C 1 0", bus.dout, bus.dout_valid, bus.sync_err);
        end
    endtask

    initial begin
        bus.s_in = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
        bus.msb_first = 1'b1;
        bus.dout_ready = 1'b0;
        bus.err_clr = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_replace();
        test_sync_err();
        test_idle_gap();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
